// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, operands and result registered.
// Latency: request handshake edge -> EXEC -> RESP, so rsp_valid rises two edges after req_ready is seen.
// Backpressure: one transaction in flight; response held until owner's rsp_ready, req_ready=00 while busy.
module alu_arbiter #(
    parameter int DATA_W = 4,
    parameter int OP_W   = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*OP_W-1:0]   req_op,
    input  logic [2*DATA_W-1:0] req_a,
    input  logic [2*DATA_W-1:0] req_b,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [DATA_W-1:0]   rsp_result,
    output logic                rsp_zero,
    output logic [DATA_W-1:0]   alu_src_a,
    output logic [DATA_W-1:0]   alu_src_b,
    output logic [OP_W-1:0]     alu_ctrl,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic                alu_zero,
    output logic                busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              zero_q, zero_d;
    logic              grant;
    logic              take;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        grant = (req_valid == 2'b11) ? ~last_q : req_valid[1];
        take  = (state_q == IDLE) && rst_n && (req_valid != 2'b00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (take) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready[owner_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        last_d  = last_q;
        owner_d = owner_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        zero_d  = zero_q;
        if (take) begin
            last_d  = grant;
            owner_d = grant;
            op_d    = grant ? req_op[OP_W +: OP_W]     : req_op[0 +: OP_W];
            a_d     = grant ? req_a[DATA_W +: DATA_W]  : req_a[0 +: DATA_W];
            b_d     = grant ? req_b[DATA_W +: DATA_W]  : req_b[0 +: DATA_W];
        end
        if (state_q == EXEC) begin
            res_d  = alu_result;
            zero_d = alu_zero;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            last_q  <= last_d;
            owner_q <= owner_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        req_ready  = 2'b00;
        rsp_valid  = 2'b00;
        alu_ctrl   = '0;
        alu_src_a  = '0;
        alu_src_b  = '0;
        if (take) req_ready = grant ? 2'b10 : 2'b01;
        if (state_q == EXEC) begin
            alu_ctrl  = op_q;
            alu_src_a = a_q;
            alu_src_b = b_q;
        end
        if (state_q == RESP) rsp_valid = owner_q ? 2'b10 : 2'b01;
        busy       = (state_q != IDLE);
        rsp_result = res_q;
        rsp_zero   = zero_q;
    end
endmodule
